// File: rtl/cmac_feeder_if.sv
// Handshake and operand bundle between the MAC-lane feeder and its neighbours:
// command port, upstream pair stream, MAC operand/result bus and result stream.
interface cmac_feeder_if #(
    parameter int DW = 16,
    parameter int CW = 12
);
    logic          start;
    logic [CW-1:0] taps;
    logic          busy;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [DW-1:0] in_weight;

    logic          mac_clr;
    logic [DW-1:0] mac_data;
    logic [DW-1:0] mac_weight;
    logic          mac_nd;
    logic          mac_rfd;
    logic          mac_rdy;
    logic [DW-1:0] mac_result;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;

    // Feeder side
    modport slave (
        input  start, taps, in_valid, in_data, in_weight,
               mac_rfd, mac_rdy, mac_result, out_ready,
        output busy, in_ready, mac_clr, mac_data, mac_weight, mac_nd,
               out_valid, out_result
    );

    // Environment side: command source, upstream, MAC and downstream writer
    modport master (
        output start, taps, in_valid, in_data, in_weight,
               mac_rfd, mac_rdy, mac_result, out_ready,
        input  busy, in_ready, mac_clr, mac_data, mac_weight, mac_nd,
               out_valid, out_result
    );
endinterface

// File: rtl/cmac_feeder.sv
// Input-side sequencer for one convolution MAC lane: clears the accumulator,
// streams tap pairs into the MAC, counts results and holds the final sum.
module cmac_feeder #(
    parameter int DW = 16,
    parameter int CW = 12
) (
    input  logic         clk,
    input  logic         rst,
    cmac_feeder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] taps_q, taps_d;
    logic [CW-1:0] issue_cnt_q, issue_cnt_d;
    logic [CW-1:0] done_cnt_q, done_cnt_d;
    logic [DW-1:0] mac_data_q, mac_data_d;
    logic [DW-1:0] mac_weight_q, mac_weight_d;
    logic [DW-1:0] out_result_q, out_result_d;
    logic          mac_nd_q, mac_nd_d;

    logic in_ready;
    logic hs;
    logic rdy_take;

    always_comb begin
        in_ready = (state_q == ISSUE) && bus.mac_rfd && (issue_cnt_q < taps_q);
        hs       = in_ready && bus.in_valid;
        rdy_take = bus.mac_rdy && ((state_q == ISSUE) || (state_q == DRAIN));
    end

    always_comb begin
        state_d      = state_q;
        taps_d       = taps_q;
        issue_cnt_d  = issue_cnt_q;
        done_cnt_d   = done_cnt_q;
        mac_data_d   = mac_data_q;
        mac_weight_d = mac_weight_q;
        out_result_d = out_result_q;
        mac_nd_d     = hs;

        if (hs) begin
            issue_cnt_d  = issue_cnt_q + CW'(1);
            mac_data_d   = bus.in_data;
            mac_weight_d = bus.in_weight;
        end
        if (rdy_take) begin
            done_cnt_d   = done_cnt_q + CW'(1);
            out_result_d = bus.mac_result;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    taps_d      = bus.taps;
                    issue_cnt_d = '0;
                    done_cnt_d  = '0;
                    // An empty command skips the MAC entirely and reports zero
                    if (bus.taps == '0) begin
                        state_d      = HOLD;
                        out_result_d = '0;
                    end else begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: state_d = ISSUE;
            ISSUE: begin
                // The last result may already be in when the last pair goes out
                if (issue_cnt_d == taps_q)
                    state_d = (done_cnt_d >= taps_q) ? HOLD : DRAIN;
            end
            DRAIN: begin
                if (done_cnt_d >= taps_q)
                    state_d = HOLD;
            end
            HOLD: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            taps_q       <= '0;
            issue_cnt_q  <= '0;
            done_cnt_q   <= '0;
            mac_data_q   <= '0;
            mac_weight_q <= '0;
            out_result_q <= '0;
            mac_nd_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            taps_q       <= taps_d;
            issue_cnt_q  <= issue_cnt_d;
            done_cnt_q   <= done_cnt_d;
            mac_data_q   <= mac_data_d;
            mac_weight_q <= mac_weight_d;
            out_result_q <= out_result_d;
            mac_nd_q     <= mac_nd_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.in_ready   = in_ready;
    assign bus.mac_clr    = (state_q == CLEAR);
    assign bus.mac_data   = mac_data_q;
    assign bus.mac_weight = mac_weight_q;
    assign bus.mac_nd     = mac_nd_q;
    assign bus.out_valid  = (state_q == HOLD);
    assign bus.out_result = out_result_q;
endmodule
